// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache refills and D-cache accesses.
// D-side has priority; a saturating starvation counter forces an I grant after STARVE_LIM D grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              icache_stall,
  output logic              dcache_stall
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_d;
  logic              cmd_we, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata, cmd_wdata_d;
  logic [DATA_W-1:0] ic_rdata_d, dc_rdata_d;
  logic              ic_done_d, dc_done_d;
  logic              mem_req_d, mem_we_d;
  logic              starve_below;

  assign starve_below = (starve_cnt < CNT_W'(STARVE_LIM));

  // State, command and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      ic_rdata   <= '0;
      dc_rdata   <= '0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_cnt_d;
      cmd_we     <= cmd_we_d;
      cmd_addr   <= cmd_addr_d;
      cmd_wdata  <= cmd_wdata_d;
      ic_rdata   <= ic_rdata_d;
      dc_rdata   <= dc_rdata_d;
      ic_done    <= ic_done_d;
      dc_done    <= dc_done_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
    end
  end

  // Next state; mem_req/mem_we/done are computed for the cycle being entered
  always_comb begin
    state_d      = state;
    starve_cnt_d = starve_cnt;
    cmd_we_d     = cmd_we;
    cmd_addr_d   = cmd_addr;
    cmd_wdata_d  = cmd_wdata;
    ic_rdata_d   = ic_rdata;
    dc_rdata_d   = dc_rdata;
    ic_done_d    = 1'b0;
    dc_done_d    = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;

    case (state)
      IDLE: begin
        if (!ic_req) starve_cnt_d = '0;
        if (dc_req && (!ic_req || starve_below)) begin
          state_d     = BUSY_D;
          cmd_we_d    = dc_we;
          cmd_addr_d  = dc_addr;
          cmd_wdata_d = dc_wdata;
          mem_req_d   = 1'b1;
          mem_we_d    = dc_we;
          // A waiting I request is only bypassed while the count is below the limit
          if (ic_req) starve_cnt_d = starve_cnt + CNT_W'(1);
        end else if (ic_req) begin
          state_d      = BUSY_I;
          cmd_we_d     = 1'b0;
          cmd_addr_d   = ic_addr;
          cmd_wdata_d  = '0;
          mem_req_d    = 1'b1;
          starve_cnt_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d    = DONE_I;
          ic_rdata_d = mem_rdata;
          ic_done_d  = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = DONE_D;
          dc_done_d = 1'b1;
          if (!cmd_we) dc_rdata_d = mem_rdata;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = cmd_we;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  // Stalls follow the live request so the pipeline freezes in the request cycle itself
  assign icache_stall = rst_n & ic_req & ~ic_done;
  assign dcache_stall = rst_n & dc_req & ~dc_done;

endmodule
